// File: rtl/ooo_config_pkg.sv
// Shared out-of-order core configuration: index widths, functional-unit
// count, branch-unit index, the CDB packet type and ROB age helpers.
package ooo_config;

    localparam int ROB_BITS   = 5;
    localparam int PREG_BITS  = 6;
    localparam int DATA_W     = 32;
    localparam int FUNC_UNITS = 5;
    // Branch unit index; it owns the fixed-priority CDB slot.
    localparam int BRU_IDX    = 4;

    typedef struct packed {
        logic [ROB_BITS-1:0]  rob_idx;
        logic [PREG_BITS-1:0] pd;
        logic [DATA_W-1:0]    data;
    } cdb_pkt_t;

    // Distance of a ROB index from the head; smaller means older.
    function automatic logic [ROB_BITS-1:0] rob_age(
        input logic [ROB_BITS-1:0] idx,
        input logic [ROB_BITS-1:0] head
    );
        return idx - head;
    endfunction

    // True when idx was allocated after the branch and must be squashed.
    function automatic logic is_younger(
        input logic [ROB_BITS-1:0] idx,
        input logic [ROB_BITS-1:0] branch,
        input logic [ROB_BITS-1:0] head
    );
        return rob_age(idx, head) > rob_age(branch, head);
    endfunction

endpackage

// File: rtl/cdb_req_buf.sv
// Per-requester circular result buffer for the CDB arbiter. Each slot carries
// a live bit so a flush can kill younger entries in place; killed slots stay
// occupied as bubbles until the owner pops them.
module cdb_req_buf
    import ooo_config::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  cdb_pkt_t            push_pkt,
    input  logic                pop,
    input  logic                flush_valid,
    input  logic [ROB_BITS-1:0] flush_rob_idx,
    input  logic [ROB_BITS-1:0] rob_head,
    output cdb_pkt_t            head_pkt,
    output logic                head_valid,
    output logic                full,
    output logic                empty
);

    localparam int PTR_W = $clog2(DEPTH);

    cdb_pkt_t             mem [DEPTH];
    logic [DEPTH-1:0]     live, live_next;
    logic [PTR_W-1:0]     head_ptr, tail_ptr;
    logic [PTR_W:0]       count;
    logic                 do_push, do_pop;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign head_pkt   = mem[head_ptr];
    assign head_valid = live[head_ptr];

    // A younger result offered during a flush is accepted but never stored.
    assign do_push = push && !full &&
                     !(flush_valid && is_younger(push_pkt.rob_idx, flush_rob_idx, rob_head));
    assign do_pop  = pop && !empty;

    // Payload write at the tail.
    // NOTE: payload slots are deliberately not reset; live bits alone say what is real.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= push_pkt;
    end

    // Next live mask: squash younger entries, retire the head, mark the new tail.
    always_comb begin
        // NOTE: default assignment first so no path leaves live_next unassigned (no latch).
        live_next = live;
        if (flush_valid) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (is_younger(mem[e].rob_idx, flush_rob_idx, rob_head)) live_next[e] = 1'b0;
            end
        end
        if (do_pop)  live_next[head_ptr] = 1'b0;
        if (do_push) live_next[tail_ptr] = 1'b1;
    end

    // Pointer, occupancy and live-bit state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            live     <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            live <= live_next;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: buffers results from NUM_REQ functional units and broadcasts
// one per cycle through a registered CDB output. The branch unit (PRIO_REQ)
// has fixed priority; the rest share the slot round-robin. Younger-than-branch
// results are squashed on flush.
// Optional build macro CDB_ARB_PERF_EN adds per-requester grant/stall counters
// on port perf_cnt.
module cdb_arbiter
    import ooo_config::*;
#(
    parameter int NUM_REQ   = FUNC_UNITS,
    parameter int BUF_DEPTH = 2,
    parameter int ROB_BITS  = ooo_config::ROB_BITS,
    parameter int PREG_BITS = ooo_config::PREG_BITS,
    parameter int DATA_W    = ooo_config::DATA_W,
    parameter int PRIO_REQ  = BRU_IDX
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][ROB_BITS-1:0]  req_rob_idx,
    input  logic [NUM_REQ-1:0][PREG_BITS-1:0] req_pd,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
    input  logic [ROB_BITS-1:0]               rob_head,
    input  logic                              flush_valid,
    input  logic [ROB_BITS-1:0]               flush_rob_idx,
    output logic                              cdb_valid,
    output logic [ROB_BITS-1:0]               cdb_rob_idx,
    output logic [PREG_BITS-1:0]              cdb_pd,
    output logic [DATA_W-1:0]                 cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]        cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ-1:0][1:0][31:0]     perf_cnt
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);

    cdb_pkt_t             head_pkt [NUM_REQ];
    logic [NUM_REQ-1:0]   head_valid, head_live, full, empty, pop;
    logic [SRC_W-1:0]     rr_ptr;
    logic                 grant_any, grant_prio, grant_kill;
    logic [SRC_W-1:0]     grant_idx;
    cdb_pkt_t             grant_pkt;

    assign req_ready = ~full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_buf
        cdb_pkt_t push_pkt;
        assign push_pkt.rob_idx = req_rob_idx[i];
        assign push_pkt.pd      = req_pd[i];
        assign push_pkt.data    = req_data[i];

        assign head_live[i] = !empty[i] && head_valid[i];
        // The granted head is popped; a squashed head is drained silently.
        assign pop[i] = (grant_any && (grant_idx == SRC_W'(i))) ||
                        (!empty[i] && !head_valid[i]);

        cdb_req_buf #(.DEPTH(BUF_DEPTH)) u_buf (
            .clk           (clk),
            .rst_n         (rst_n),
            .push          (req_valid[i]),
            .push_pkt      (push_pkt),
            .pop           (pop[i]),
            .flush_valid   (flush_valid),
            .flush_rob_idx (flush_rob_idx),
            .rob_head      (rob_head),
            .head_pkt      (head_pkt[i]),
            .head_valid    (head_valid[i]),
            .full          (full[i]),
            .empty         (empty[i])
        );
    end

    // Grant selection: branch unit first, otherwise first live head from rr_ptr.
    always_comb begin
        int idx;
        grant_any  = 1'b0;
        grant_prio = 1'b0;
        grant_idx  = '0;
        idx        = 0;
        if (head_live[PRIO_REQ]) begin
            grant_any  = 1'b1;
            grant_prio = 1'b1;
            grant_idx  = SRC_W'(PRIO_REQ);
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && head_live[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(idx);
                end
            end
        end
    end

    assign grant_pkt  = head_pkt[grant_idx];
    // A grant racing a flush that kills it is popped but never broadcast.
    assign grant_kill = grant_any && flush_valid &&
                        is_younger(grant_pkt.rob_idx, flush_rob_idx, rob_head);

    // Round-robin pointer advances past each non-priority winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any && !grant_prio) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    // Registered CDB broadcast slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid   <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_pd      <= '0;
            cdb_data    <= '0;
            cdb_src     <= '0;
        end else if (grant_any && !grant_kill) begin
            cdb_valid   <= 1'b1;
            cdb_rob_idx <= grant_pkt.rob_idx;
            cdb_pd      <= grant_pkt.pd;
            cdb_data    <= grant_pkt.data;
            cdb_src     <= grant_idx;
        end else begin
            cdb_valid <= 1'b0;
            if (flush_valid && cdb_valid &&
                is_younger(cdb_rob_idx, flush_rob_idx, rob_head)) begin
                cdb_rob_idx <= '0;
                cdb_pd      <= '0;
                cdb_data    <= '0;
                cdb_src     <= '0;
            end
        end
    end

`ifdef CDB_ARB_PERF_EN
    // Saturating per-requester grant ([0]) and stall ([1]) counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_any && (grant_idx == SRC_W'(i)) && (perf_cnt[i][0] != '1))
                    perf_cnt[i][0] <= perf_cnt[i][0] + 32'd1;
                if (req_valid[i] && full[i] && (perf_cnt[i][1] != '1))
                    perf_cnt[i][1] <= perf_cnt[i][1] + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-requester scoreboard queues filled at
// stimulus time and drained by a CDB monitor, plus cycle-exact checks of
// arbitration order, backpressure, flush and asynchronous reset.
module tb_cdb_arbiter;

    localparam int NR = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0][4:0]  req_rob_idx;
    logic [NR-1:0][5:0]  req_pd;
    logic [NR-1:0][31:0] req_data;
    logic [4:0]       rob_head;
    logic             flush_valid;
    logic [4:0]       flush_rob_idx;
    logic             cdb_valid;
    logic [4:0]       cdb_rob_idx;
    logic [5:0]       cdb_pd;
    logic [31:0]      cdb_data;
    logic [2:0]       cdb_src;
`ifdef CDB_ARB_PERF_EN
    logic [NR-1:0][1:0][31:0] perf_cnt;
`endif

    typedef struct packed {
        logic [4:0]  rob;
        logic [5:0]  pd;
        logic [31:0] data;
    } exp_t;

    exp_t expq [NR][$];
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rob_idx   (req_rob_idx),
        .req_pd        (req_pd),
        .req_data      (req_data),
        .rob_head      (rob_head),
        .flush_valid   (flush_valid),
        .flush_rob_idx (flush_rob_idx),
        .cdb_valid     (cdb_valid),
        .cdb_rob_idx   (cdb_rob_idx),
        .cdb_pd        (cdb_pd),
        .cdb_data      (cdb_data),
        .cdb_src       (cdb_src)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_cnt      (perf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int i, input logic [4:0] rob);
        exp_t e;
        e.rob  = rob;
        e.pd   = 6'((i * 10 + int'(rob)) % 64);
        e.data = 32'hD000_0000 | (32'(i) << 8) | 32'(rob);
        return e;
    endfunction

    // Offer a result on requester i; accept=1 means the bench expects it broadcast.
    task automatic offer(input int i, input logic [4:0] rob, input bit accept);
        exp_t e;
        e = mk(i, rob);
        req_valid[i]   = 1'b1;
        req_rob_idx[i] = e.rob;
        req_pd[i]      = e.pd;
        req_data[i]    = e.data;
        if (accept) expq[i].push_back(e);
    endtask

    task automatic clear_req();
        req_valid   = '0;
        flush_valid = 1'b0;
    endtask

    // CDB monitor: every broadcast must match the oldest expected entry of its source.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && cdb_valid === 1'b1) begin
            check("bcast_src_range", 64'(cdb_src < 3'd5), 64'd1);
            if (cdb_src < 3'd5) begin
                check("bcast_expected", 64'(expq[cdb_src].size() != 0), 64'd1);
                if (expq[cdb_src].size() != 0) begin
                    e = expq[cdb_src].pop_front();
                    check("bcast_payload", 64'({cdb_rob_idx, cdb_pd, cdb_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_rob_idx   = '0;
        req_pd        = '0;
        req_data      = '0;
        rob_head      = '0;
        flush_valid   = 1'b0;
        flush_rob_idx = '0;

        // Reset, then idle.
        #2;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        check("rst_fields", 64'({cdb_rob_idx, cdb_pd, cdb_data, cdb_src}), 64'd0);
        for (int n = 0; n < 20; n++) begin
            cyc();
            check("idle_valid", 64'(cdb_valid), 64'd0);
            check("idle_ready", 64'(req_ready), 64'h1f);
        end

        // Round robin: 0,1,2 offered together; broadcast in ascending order.
        offer(0, 5'd3, 1'b1);
        offer(1, 5'd4, 1'b1);
        offer(2, 5'd5, 1'b1);
        cyc();
        clear_req();
        check("rr_not_yet", 64'(cdb_valid), 64'd0);
        cyc();
        check("rr_v0", 64'(cdb_valid), 64'd1);
        check("rr_src0", 64'(cdb_src), 64'd0);
        cyc();
        check("rr_src1", 64'(cdb_src), 64'd1);
        cyc();
        check("rr_src2", 64'(cdb_src), 64'd2);
        cyc();
        check("rr_done", 64'(cdb_valid), 64'd0);

        // Move rr_ptr to 1 with a single grant of requester 0.
        offer(0, 5'd6, 1'b1);
        cyc();
        clear_req();
        cyc();
        check("rr_set_src", 64'(cdb_src), 64'd0);
        cyc();
        check("rr_set_done", 64'(cdb_valid), 64'd0);

        // Priority: 4 wins first; rr_ptr still 1 so 1 precedes 0.
        offer(0, 5'd9, 1'b1);
        offer(1, 5'd7, 1'b1);
        offer(4, 5'd8, 1'b1);
        cyc();
        clear_req();
        cyc();
        check("prio_src4", 64'(cdb_src), 64'd4);
        cyc();
        check("prio_src1", 64'(cdb_src), 64'd1);
        cyc();
        check("prio_src0", 64'(cdb_src), 64'd0);
        cyc();
        check("prio_done", 64'(cdb_valid), 64'd0);

        // Backpressure: branch unit busy every cycle, requester 0 fills up.
        for (int k = 0; k < 4; k++) begin
            offer(4, 5'(12 + k), 1'b1);
            offer(0, 5'(20 + k), k < 2);
            check($sformatf("bp_ready0_%0d", k), 64'(req_ready[0]), 64'(k < 2));
            check($sformatf("bp_ready4_%0d", k), 64'(req_ready[4]), 64'd1);
            cyc();
            if (k > 0) check($sformatf("bp_src4_%0d", k), 64'(cdb_src), 64'd4);
        end
        clear_req();
        repeat (5) cyc();
        check("bp_drained_valid", 64'(cdb_valid), 64'd0);
        check("bp_drained_ready", 64'(req_ready), 64'h1f);

        // Flush: head 30, branch 1; 31 is older, 2 and 3 are younger.
        rob_head = 5'd30;
        offer(1, 5'd31, 1'b1);
        offer(2, 5'd2, 1'b0);
        cyc();
        clear_req();
        flush_valid   = 1'b1;
        flush_rob_idx = 5'd1;
        offer(3, 5'd3, 1'b0);
        check("flush_ready3", 64'(req_ready[3]), 64'd1);
        cyc();
        clear_req();
        check("flush_keep_valid", 64'(cdb_valid), 64'd1);
        check("flush_keep_src", 64'(cdb_src), 64'd1);
        check("flush_keep_rob", 64'(cdb_rob_idx), 64'd31);
        for (int n = 0; n < 4; n++) begin
            cyc();
            check("flush_idle", 64'(cdb_valid), 64'd0);
        end
        check("flush_ready_after", 64'(req_ready), 64'h1f);

        // Asynchronous reset mid-burst with three entries buffered.
        rob_head = 5'd0;
        offer(0, 5'd5, 1'b0);
        offer(1, 5'd6, 1'b0);
        offer(2, 5'd7, 1'b0);
        cyc();
        clear_req();
        offer(3, 5'd8, 1'b0);
        cyc();
        clear_req();
        check("mid_valid", 64'(cdb_valid), 64'd1);
        check("mid_src", 64'(cdb_src), 64'd2);
        check("mid_rob", 64'(cdb_rob_idx), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(cdb_valid), 64'd0);
        check("async_fields", 64'({cdb_rob_idx, cdb_src}), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            check("post_rst_valid", 64'(cdb_valid), 64'd0);
            check("post_rst_ready", 64'(req_ready), 64'h1f);
        end

        // Every expected broadcast must have been seen.
        for (int i = 0; i < NR; i++) begin
            check($sformatf("sb_empty_%0d", i), 64'(expq[i].size()), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) broadcast slot among NUM_REQ functional-unit result producers.
- Each requester has a small per-port result buffer. One buffered result per cycle is granted and driven onto a registered CDB output.
- The ROB, reservation stations and register file consume that output.
- Results younger than a mispredicted branch are squashed on flush.

Parameters:
- NUM_REQ, 5, number of functional-unit requesters.
- BUF_DEPTH, 2, entries per requester buffer (power of two, >=2).
- ROB_BITS, 5, ROB index width.
- PREG_BITS, 6, physical register index width.
- DATA_W, 32, result width.
- PRIO_REQ, 4, requester index with fixed priority (branch unit).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  result offered by requester i.
- req_ready  out  NUM_REQ  buffer i can accept this cycle.
- req_rob_idx  in  NUM_REQ x ROB_BITS  ROB index of result i.
- req_pd  in  NUM_REQ x PREG_BITS  destination physical register.
- req_data  in  NUM_REQ x DATA_W  result value.
- rob_head  in  ROB_BITS  current ROB head index (age reference).
- flush_valid  in  1  mispredict resolved this cycle.
- flush_rob_idx  in  ROB_BITS  ROB index of the mispredicted branch.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_idx  out  ROB_BITS  broadcast ROB index.
- cdb_pd  out  PREG_BITS  broadcast physical register.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(NUM_REQ)  granted requester id.

Behaviour:
- Reset (rst_n low, asynchronous): all buffers empty; round-robin pointer = 0; cdb_valid = 0; cdb_rob_idx/pd/data/src = 0; req_ready = all 1 once reset deasserts.
- Enqueue: the handshake is req_valid & req_ready at the posedge. The entry is written to buffer i tail.
  - req_ready[i] = !full[i]. It is registered-state based and does not depend on this cycle's grant.
- Grant, combinational from buffer heads:
  - If buffer PRIO_REQ is non-empty, it wins.
  - Otherwise, the first non-empty buffer at or after rr_ptr, in ascending wrap order, wins.
  - On a non-priority grant, rr_ptr <= granted+1 mod NUM_REQ. rr_ptr is unchanged on a priority grant or when there is no grant.
- Output register: the granted head is popped and loaded into the cdb_* registers at the posedge. cdb_valid = 1 iff a grant occurred.
  - Every grant pops exactly one entry.
  - Latency: a result accepted at edge N is broadcast no earlier than the cycle after edge N+1, i.e. 2 cycles minimum.
- Simultaneous push and pop on the same buffer is legal.
  - When full, req_ready is 0 that cycle, even if a pop occurs.
- Age: age(x) = (x - rob_head) mod 2^ROB_BITS. An entry is younger than the branch iff age(entry) > age(flush_rob_idx).
- Flush, when flush_valid = 1:
  - Buffered entries younger than the branch are invalidated this edge; older entries are kept in order (compaction not required, bubbles allowed).
  - Same-cycle enqueues of younger results are dropped, though the handshake still completes.
  - A grant of a younger entry this cycle is suppressed, so cdb_valid = 0 next cycle.
  - An output register already holding a younger entry is cleared at the edge.
  - The branch itself is never squashed.
- Invalidated entries are skipped by the grant logic and popped without broadcast.
- No result is ever broadcast twice or reordered within one requester.
- A reset mid-operation discards all buffered and in-flight results.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- When defined, the block adds 32-bit saturating counters perf_grant[NUM_REQ] and perf_stall[NUM_REQ]:
  - perf_grant counts grants per requester.
  - perf_stall counts cycles with req_valid & !req_ready.
  - Both are exposed as output port perf_cnt (NUM_REQ x 2 x 32), reset to 0, and saturate at 32'hFFFF_FFFF.
- When undefined, neither the port nor the counters exist.

Decomposition:
- ooo_config package holds:
  - typedef cdb_pkt_t {rob_idx, pd, data}.
  - ROB_BITS, PREG_BITS, FUNC_UNITS and the BRU index constants.
  - function rob_age(idx, head).
- Sub-module cdb_req_buf: per-requester circular buffer, one instance per requester, with:
  - per-entry valid bits;
  - flush-squash logic;
  - push/pop/full/empty ports.

Test Plan:
- Reset then idle: no req_valid -> cdb_valid stays 0 and req_ready = 5'b11111 for 20 cycles.
- Round robin: requesters 0,1,2 each push one result in the same cycle (rob_idx 3,4,5) -> broadcasts in cycles +2,+3,+4 with cdb_src 0,1,2.
- Priority: requesters 1 and 4 are non-empty, rr_ptr=1 -> cdb_src=4 is broadcast first, then 1; rr_ptr stays 1 after the priority grant.
- Backpressure: requester 0 is held valid for 4 cycles with no grant (priority requester kept busy) -> req_ready[0]=0 after 2 accepts, and no data is lost once drained.
- Flush: rob_head=30, branch idx 1, buffered idx 31 and 2 -> idx 31 is broadcast and idx 2 is never broadcast; a same-cycle push of idx 3 is dropped.
- Async reset asserted mid-burst with 3 entries buffered -> cdb_valid=0 immediately, and nothing is broadcast after release.
